// File: rtl/cp0_pkg.sv
// cp0_pkg: shared encodings for the nested coprocessor-0 controller.
`default_nettype none

package cp0_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MTC0 = 3'd1,
    OP_MFC0 = 3'd2,
    OP_ERET = 3'd3
  } cp_op_e;

  localparam logic [4:0] REG_EBASE  = 5'd3;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_DEPTH  = 5'd15;

  localparam int ST_IE  = 0;
  localparam int ST_OVF = 31;

  localparam int CAUSE_UNDEF = 1;
  localparam int CAUSE_OVF   = 2;
  localparam int CAUSE_RANGE = 4;

endpackage

`default_nettype wire

// File: rtl/cp0_ring_stack.sv
// cp0_ring_stack: LIFO of {epc, ring} save slots; push+pop together replaces the top.
`default_nettype none

module cp0_ring_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RW    = 3,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   push_epc,
  input  logic [RW-1:0] push_ring,
  input  logic          wr_top,
  input  logic [31:0]   wr_epc,
  output logic          full,
  output logic          empty,
  output logic [31:0]   top_epc,
  output logic [RW-1:0] top_ring,
  output logic [AW:0]   count
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [31:0]   epc_mem  [DEPTH];
  logic [RW-1:0] ring_mem [DEPTH];
  logic [AW:0]   sp;
  logic [AW-1:0] top_idx;

  assign full     = (sp == (AW+1)'(DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = AW'(sp - ONE);
  assign top_epc  = epc_mem[top_idx];
  assign top_ring = ring_mem[top_idx];
  assign count    = sp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        epc_mem[i]  <= '0;
        ring_mem[i] <= '0;
      end
    end else begin
      if (wr_top && !empty)
        epc_mem[top_idx] <= wr_epc;
      if (push && pop && !empty) begin
        epc_mem[top_idx]  <= push_epc;
        ring_mem[top_idx] <= push_ring;
      end else if (push && !full) begin
        epc_mem[sp[AW-1:0]]  <= push_epc;
        ring_mem[sp[AW-1:0]] <= push_ring;
        sp <= sp + ONE;
      end else if (pop && !empty) begin
        sp <= sp - ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cp0_nested.sv
// cp0_nested: CP0 controller with prioritised nested interrupts, exceptions,
// ERET and vectored dispatch, backed by an EPC/ring save stack.
`default_nettype none

module cp0_nested
  import cp0_pkg::*;
#(
  parameter int unsigned N_LVL       = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CAUSE_W     = 3,
  parameter int unsigned VEC_SHIFT   = 3,
  parameter logic [31:0] EBASE_RST   = 32'h0000_0024,
  localparam int unsigned LW         = $clog2(N_LVL + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_en,
  input  logic [2:0]         cp_oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic [CAUSE_W-1:0] cause,
  input  logic [LW-1:0]      irq_level,
  input  logic [31:0]        ex_pc,
  input  logic [31:0]        id_pc,
  output logic               epc_ctrl,
  output logic [31:0]        jump_addr,
  output logic               except_clear,
  output logic               eret_clear,
  output logic [LW-1:0]      ring,
  output logic               stk_ovf
);

  localparam int unsigned PW = $clog2(STACK_DEPTH) + 1;

  logic [31:0]   regs [32];
  logic [31:0]   ebase, rd_val, exc_vec, irq_vec, cause_val, jump_nxt, push_epc;
  logic [31:0]   top_epc;
  logic [LW-1:0] top_ring, ring_nxt;
  logic [PW-1:0] depth;
  logic [4:0]    irq_idx;
  logic          ie, mtc0, exc_take, eret_take, irq_take, evt_take, evt_full;
  logic          push, pop, wr_top, full, empty, evt_pend;

  cp0_ring_stack #(
    .DEPTH (STACK_DEPTH),
    .RW    (LW)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_epc  (push_epc),
    .push_ring (ring),
    .wr_top    (wr_top),
    .wr_epc    (data_w),
    .full      (full),
    .empty     (empty),
    .top_epc   (top_epc),
    .top_ring  (top_ring),
    .count     (depth)
  );

  always_comb begin
    ebase    = regs[REG_EBASE];
    ie       = regs[REG_STATUS][ST_IE];
    irq_idx  = 5'(irq_level);
    mtc0     = cpu_en && (cp_oper == OP_MTC0);
    wr_top   = mtc0 && (addr_w == REG_EPC);

    // Priority: exception, then ERET, then interrupt.
    exc_take  = cpu_en && (cause != '0) && ie;
    eret_take = cpu_en && !exc_take && (cp_oper == OP_ERET);
    irq_take  = cpu_en && !exc_take && !eret_take && ie && (irq_level != '0) &&
                (32'(irq_level) <= N_LVL) && (irq_level > ring) &&
                regs[REG_STATUS][irq_idx];
    evt_take  = exc_take | irq_take;
    evt_full  = evt_take & full;
    push      = evt_take & ~full;
    pop       = eret_take & ~empty;
    push_epc  = exc_take ? (ex_pc + 32'd4) : id_pc;

    exc_vec = ebase + (32'(cause) << VEC_SHIFT);
    irq_vec = ebase + ((32'((1 << CAUSE_W) - 1) + 32'(irq_level)) << VEC_SHIFT);

    ring_nxt  = ring;
    jump_nxt  = jump_addr;
    cause_val = regs[REG_CAUSE];
    if (exc_take) begin
      ring_nxt  = LW'(N_LVL);
      jump_nxt  = full ? ebase : exc_vec;
      cause_val = {16'h0, 8'(N_LVL), 8'(cause)};
    end else if (eret_take) begin
      ring_nxt = empty ? '0 : top_ring;
      jump_nxt = empty ? regs[REG_EPC] : top_epc;
    end else if (irq_take) begin
      ring_nxt  = full ? LW'(N_LVL) : irq_level;
      jump_nxt  = full ? ebase : irq_vec;
      cause_val = {16'h0, 8'(irq_level), 8'h0};
    end

    case (addr_r)
      REG_EPC:    rd_val = empty ? regs[REG_EPC] : top_epc;
      REG_DEPTH:  rd_val = 32'(depth);
      REG_STATUS: rd_val = {stk_ovf, regs[REG_STATUS][30:0]};
      default:    rd_val = regs[addr_r];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[REG_EBASE] <= EBASE_RST;
      data_r       <= '0;
      ring         <= '0;
      jump_addr    <= '0;
      epc_ctrl     <= 1'b0;
      eret_clear   <= 1'b0;
      evt_pend     <= 1'b0;
      except_clear <= 1'b0;
      stk_ovf      <= 1'b0;
    end else begin
      if (mtc0 && (addr_w != REG_DEPTH))
        regs[addr_w] <= data_w;
      if (evt_take)
        regs[REG_CAUSE] <= cause_val;
      if (cpu_en && (cp_oper == OP_MFC0))
        data_r <= rd_val;
      ring      <= ring_nxt;
      jump_addr <= jump_nxt;
      // Flush requests stay up while the pipeline is stalled.
      epc_ctrl     <= evt_take | eret_take | (epc_ctrl & ~cpu_en);
      eret_clear   <= eret_take | (eret_clear & ~cpu_en);
      evt_pend     <= evt_take;
      except_clear <= evt_pend;
      if (evt_full)
        stk_ovf <= 1'b1;
      else if (mtc0 && (addr_w == REG_STATUS) && !data_w[ST_OVF])
        stk_ovf <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_nested.sv
// tb_cp0_nested: directed and randomized checks of cp0_nested against a queue-based model.
`default_nettype none

module tb_cp0_nested;

  localparam int N_LVL = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int VSTEP = 8;
  localparam logic [31:0] EB_RST = 32'h0000_0024;

  logic        clk = 1'b0;
  logic        rst_n, cpu_en;
  logic [2:0]  cp_oper, cause;
  logic [4:0]  addr_r, addr_w;
  logic [31:0] data_w, ex_pc, id_pc;
  logic [LW-1:0] irq_level;
  logic [31:0] data_r, jump_addr;
  logic        epc_ctrl, except_clear, eret_clear, stk_ovf;
  logic [LW-1:0] ring;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  cp0_nested dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .cp_oper(cp_oper),
    .addr_r(addr_r), .data_r(data_r), .addr_w(addr_w), .data_w(data_w),
    .cause(cause), .irq_level(irq_level), .ex_pc(ex_pc), .id_pc(id_pc),
    .epc_ctrl(epc_ctrl), .jump_addr(jump_addr), .except_clear(except_clear),
    .eret_clear(eret_clear), .ring(ring), .stk_ovf(stk_ovf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] epc; int rg; } ent_t;
  ent_t        stk[$];
  logic [31:0] m_regs [32];
  int          m_ring;
  logic [31:0] m_jump, m_data_r;
  bit          m_epc_ctrl, m_eret_clear, m_except_clear, m_taken_d, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[3] = EB_RST;
    stk.delete();
    m_ring = 0; m_jump = 0; m_data_r = 0;
    m_epc_ctrl = 0; m_eret_clear = 0; m_except_clear = 0; m_taken_d = 0; m_ovf = 0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    case (a)
      14:      return (stk.size() > 0) ? stk[stk.size()-1].epc : m_regs[14];
      15:      return 32'(stk.size());
      12:      return {m_ovf, m_regs[12][30:0]};
      default: return m_regs[a];
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] rd, eb, epc_reg;
    bit ie, full, exc, er, irq;
    int lvl;
    ent_t e;
    if (!rst_n) return;
    rd      = model_read(int'(addr_r));
    eb      = m_regs[3];
    epc_reg = m_regs[14];
    ie      = m_regs[12][0];
    full    = (stk.size() == DEPTH);
    lvl     = int'(irq_level);
    exc = cpu_en && (cause != 0) && ie;
    er  = cpu_en && !exc && (cp_oper == 3);
    irq = cpu_en && !exc && !er && ie && lvl > 0 && lvl <= N_LVL && lvl > m_ring && m_regs[12][lvl];

    if (cpu_en && cp_oper == 2) m_data_r = rd;
    if (cpu_en && cp_oper == 1) begin
      if (addr_w == 14 && stk.size() > 0) stk[stk.size()-1].epc = data_w;
      if (addr_w != 15) m_regs[addr_w] = data_w;
      if (addr_w == 12 && !data_w[31]) m_ovf = 0;
    end

    m_epc_ctrl     = exc || er || irq || (m_epc_ctrl && !cpu_en);
    m_eret_clear   = er || (m_eret_clear && !cpu_en);
    m_except_clear = m_taken_d;
    m_taken_d      = exc || irq;

    if (exc || irq) begin
      m_regs[13] = exc ? {16'h0, 8'(N_LVL), 5'h0, cause} : {16'h0, 8'(lvl), 8'h0};
      if (full) begin
        m_ovf  = 1;
        m_jump = eb;
        m_ring = N_LVL;
      end else begin
        e.epc = exc ? ex_pc + 32'd4 : id_pc;
        e.rg  = m_ring;
        stk.push_back(e);
        m_jump = exc ? eb + 32'(int'(cause)) * VSTEP : eb + 32'(7 + lvl) * VSTEP;
        m_ring = exc ? N_LVL : lvl;
      end
    end else if (er) begin
      if (stk.size() > 0) begin
        e = stk.pop_back();
        m_jump = e.epc;
        m_ring = e.rg;
      end else begin
        m_jump = epc_reg;
        m_ring = 0;
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("epc_ctrl", 32'(epc_ctrl), 32'(m_epc_ctrl));
      check("eret_clear", 32'(eret_clear), 32'(m_eret_clear));
      check("except_clear", 32'(except_clear), 32'(m_except_clear));
      check("ring", 32'(ring), 32'(m_ring));
      check("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
      check("jump_addr", jump_addr, m_jump);
      check("data_r", data_r, m_data_r);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle();
    cpu_en = 1; cp_oper = 0; cause = 0; irq_level = 0;
  endtask

  task automatic mfc(input logic [4:0] a, input logic [31:0] exp, input string name);
    cp_oper = 3'd2; addr_r = a;
    step();
    cp_oper = 3'd0;
    check(name, data_r, exp);
  endtask

  task automatic mtc(input logic [4:0] a, input logic [31:0] d);
    cp_oper = 3'd1; addr_w = a; data_w = d;
    step();
    cp_oper = 3'd0;
  endtask

  task automatic eret();
    cp_oper = 3'd3;
    step();
    cp_oper = 3'd0;
  endtask

  task automatic irq(input int lvl, input logic [31:0] pc);
    irq_level = LW'(lvl); id_pc = pc;
    step();
    irq_level = 0;
  endtask

  initial begin
    int r;
    rst_n = 0; idle();
    addr_r = 0; addr_w = 0; data_w = 0; ex_pc = 0; id_pc = 0;
    model_reset();
    step(); step();
    check("rst_ring", 32'(ring), 32'd0);
    check("rst_epc_ctrl", 32'(epc_ctrl), 32'd0);
    rst_n = 1;
    mfc(5'd3, 32'h24, "rst_ebase");
    mfc(5'd15, 32'd0, "rst_depth");

    // Exception, then return.
    mtc(5'd12, 32'h1F);
    cause = 3'd2; ex_pc = 32'h100;
    step();
    cause = 0;
    check("exc_jump", jump_addr, 32'h34);
    check("exc_ring", 32'(ring), 32'd4);
    check("exc_ctrl", 32'(epc_ctrl), 32'd1);
    check("exc_clr_early", 32'(except_clear), 32'd0);
    step();
    check("exc_clr", 32'(except_clear), 32'd1);
    mfc(5'd14, 32'h104, "exc_epc");
    mfc(5'd13, 32'h0402, "exc_cause");
    eret();
    check("eret_jump", jump_addr, 32'h104);
    check("eret_ring", 32'(ring), 32'd0);
    check("eret_clr", 32'(eret_clear), 32'd1);

    // Nesting with a blocked lower level, deferred until ERET.
    irq(1, 32'h200);
    check("n1_jump", jump_addr, 32'h64);
    irq(3, 32'h300);
    check("n3_jump", jump_addr, 32'h74);
    check("n3_ring", 32'(ring), 32'd3);
    irq_level = 3'd2;
    step();
    check("n2_blocked", 32'(epc_ctrl), 32'd0);
    mfc(5'd15, 32'd2, "n_depth");
    id_pc = 32'h400; cp_oper = 3'd3;
    step();
    cp_oper = 0;
    check("n_eret_jump", jump_addr, 32'h300);
    check("n_eret_ring", 32'(ring), 32'd1);
    step();
    irq_level = 0;
    check("n2_jump", jump_addr, 32'h6C);
    check("n2_ring", 32'(ring), 32'd2);
    eret();
    check("n_unwind1", jump_addr, 32'h400);
    eret();
    check("n_unwind2", jump_addr, 32'h200);
    check("n_unwind_ring", 32'(ring), 32'd0);

    // Exception beats a simultaneous interrupt.
    cause = 3'd1; irq_level = 3'd3; ex_pc = 32'h500;
    step();
    cause = 0;
    check("ei_jump", jump_addr, 32'h2C);
    step();
    check("ei_irq_held", 32'(epc_ctrl), 32'd0);
    cp_oper = 3'd3;
    step();
    cp_oper = 0;
    check("ei_eret", jump_addr, 32'h504);
    step();
    check("ei_irq_jump", jump_addr, 32'h74);
    irq_level = 0;
    eret();

    // Stack overflow and sticky flag.
    irq(1, 32'h1000); irq(2, 32'h2000); irq(3, 32'h3000); irq(4, 32'h4000);
    cause = 3'd4; ex_pc = 32'h600;
    step();
    cause = 0;
    check("ovf_jump", jump_addr, 32'h24);
    check("ovf_flag", 32'(stk_ovf), 32'd1);
    check("ovf_ring", 32'(ring), 32'd4);
    mfc(5'd15, 32'd4, "ovf_depth");
    mtc(5'd12, 32'h8000_001F);
    check("ovf_sticky", 32'(stk_ovf), 32'd1);
    mtc(5'd12, 32'h1F);
    check("ovf_clear", 32'(stk_ovf), 32'd0);
    eret();
    check("ovf_pop", jump_addr, 32'h4000);
    eret(); eret(); eret();
    mtc(5'd14, 32'hABC);
    mtc(5'd15, 32'd5);
    eret();
    check("empty_eret", jump_addr, 32'hABC);
    check("empty_ring", 32'(ring), 32'd0);
    mfc(5'd15, 32'd0, "empty_depth");

    // EPC overwrite and stall hold.
    irq(1, 32'h800);
    mtc(5'd14, 32'h900);
    eret();
    check("wtop_jump", jump_addr, 32'h900);
    cpu_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 32'(epc_ctrl), 32'd1);
    end
    cpu_en = 1;
    check("stall_last", 32'(epc_ctrl), 32'd1);
    step();
    check("stall_drop", 32'(epc_ctrl), 32'd0);
    check("stall_eret_drop", 32'(eret_clear), 32'd0);

    // Asynchronous reset in the middle of an interrupt.
    irq(2, 32'hA00);
    rst_n = 0;
    model_reset();
    #1;
    check("mid_rst_ring", 32'(ring), 32'd0);
    check("mid_rst_ctrl", 32'(epc_ctrl), 32'd0);
    step();
    rst_n = 1;
    mfc(5'd3, 32'h24, "mid_rst_ebase");
    mfc(5'd15, 32'd0, "mid_rst_depth");
    mtc(5'd12, 32'h1F);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      cpu_en = ($urandom_range(0, 9) != 0);
      r = int'($urandom_range(0, 99));
      cp_oper = (r < 15) ? 3'd3 : (r < 30) ? 3'd1 : (r < 55) ? 3'd2 : 3'd0;
      cause = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      irq_level = LW'($urandom_range(0, 4));
      ex_pc = $urandom & 32'hFFFF_FFFC;
      id_pc = $urandom & 32'hFFFF_FFFC;
      addr_r = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 15)) : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: addr_w = 5'd3;
        1, 2: addr_w = 5'd12;
        3: addr_w = 5'd14;
        4: addr_w = 5'd15;
        default: addr_w = 5'($urandom_range(0, 31));
      endcase
      data_w = $urandom;
      if (addr_w == 5'd12) data_w[0] = ($urandom_range(0, 7) != 0);
      if (addr_w == 5'd3)  data_w = data_w & 32'h0000_FFF8;
      if (c == 1500) begin
        rst_n = 0;
        model_reset();
      end
      if (c == 1502) rst_n = 1;
      step();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
